// File: rtl/countdown_timer.sv
// countdown_timer: loadable minutes:seconds down-counter with expiry flag.
//
// Loads a preset time, counts down once per external 1 Hz tick while running
// and flags expiry when the count reaches 00:00.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tick      one-cycle enable pulse, once per second
//   clr       synchronous clear to 00:00 and IDLE (highest priority)
//   load      load preset from load_min/load_sec (ignored while running)
//   load_min  preset minutes, saturated to MAX_MIN
//   load_sec  preset seconds, saturated to 59
//   start     begin or resume the countdown
//   pause     suspend the countdown
//   minutes   current minutes
//   seconds   current seconds, 0..59
//   running   high while counting down
//   expired   high while parked at 00:00 after an expiry
//   done      one-cycle pulse on the edge the count reaches 00:00
module countdown_timer #(
  parameter int unsigned MAX_MIN = 199,
  parameter int unsigned MIN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clr,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             start,
  input  logic             pause,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic             running,
  output logic             expired,
  output logic             done
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StPaused  = 2'd2;
  localparam logic [1:0] StExpired = 2'd3;

  localparam logic [MIN_W-1:0] MaxMin = MIN_W'(MAX_MIN);
  localparam logic [5:0]       MaxSec = 6'd59;

  logic [1:0]       state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             done_q, done_d;

  logic count_zero;
  logic count_one;

  assign count_zero = (min_q == '0) && (sec_q == '0);
  assign count_one  = (min_q == '0) && (sec_q == 6'd1);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;

    if (clr) begin
      state_d = StIdle;
      min_d   = '0;
      sec_d   = '0;
    end else if (load && (state_q != StRun)) begin
      state_d = StIdle;
      min_d   = (load_min > MaxMin) ? MaxMin : load_min;
      sec_d   = (load_sec > MaxSec) ? MaxSec : load_sec;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A zero preset cannot start; otherwise it would expire with no tick.
          if (!pause && start && !count_zero) state_d = StRun;
        end
        StRun: begin
          if (pause) begin
            state_d = StPaused;
          end else if (tick && !count_zero) begin
            if (sec_q != '0) begin
              sec_d = sec_q - 6'd1;
            end else begin
              min_d = min_q - 1'b1;
              sec_d = MaxSec;
            end
            if (count_one) begin
              state_d = StExpired;
              done_d  = 1'b1;
            end
          end
        end
        StPaused: begin
          if (!pause && start) state_d = StRun;
        end
        StExpired: begin
          // Parked at 00:00 until load or clr.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      min_q   <= '0;
      sec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign running = (state_q == StRun);
  assign expired = (state_q == StExpired);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: the driver issues one input vector per
// cycle and queues the hand-computed outputs expected after the next edge; an
// independent monitor pops and compares one entry after every rising edge.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       clr;
  logic       load;
  logic [7:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       pause;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       expired;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] m;
    logic [5:0] s;
    logic       r;
    logic       e;
    logic       d;
  } exp_t;

  exp_t exp_q[$];

  countdown_timer #(
    .MAX_MIN (199),
    .MIN_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .clr      (clr),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .minutes  (minutes),
    .seconds  (seconds),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input exp_t x);
    checks++;
    if (minutes !== x.m || seconds !== x.s || running !== x.r || expired !== x.e ||
        done !== x.d) begin
      errors++;
      $display("FAIL %s: got %0d:%0d run=%b exp=%b done=%b, expected %0d:%0d run=%b exp=%b done=%b",
               x.name, minutes, seconds, running, expired, done,
               x.m, x.s, x.r, x.e, x.d);
    end
  endtask

  // Monitor: one expectation per rising edge, sampled after the edge settles.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) compare(exp_q.pop_front());
  end

  // Drive one cycle of inputs (called just after a falling edge) and queue the
  // outputs expected after the following rising edge.
  task automatic step(input string name, input logic t, input logic c, input logic l,
                      input logic st, input logic p, input logic [7:0] lm,
                      input logic [5:0] ls, input logic [7:0] em, input logic [5:0] es,
                      input logic er, input logic ee, input logic ed);
    exp_t x;
    tick = t; clr = c; load = l; start = st; pause = p;
    load_min = lm; load_sec = ls;
    x.name = name; x.m = em; x.s = es; x.r = er; x.e = ee; x.d = ed;
    exp_q.push_back(x);
    @(negedge clk);
    tick = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [7:0] em, input logic [5:0] es,
                           input logic er, input logic ee, input logic ed);
    exp_t x;
    x.name = name; x.m = em; x.s = es; x.r = er; x.e = ee; x.d = ed;
    compare(x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rem;
    rst_n = 1'b0; tick = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_min = '0; load_sec = '0;
    repeat (2) @(negedge clk);
    check_now("reset", 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    //              name             t  c  l  st p  lm     ls     em     es    r  e  d
    step("load_2_05",   0, 0, 1, 0, 0, 8'd2,  6'd5,  8'd2,  6'd5, 0, 0, 0);
    step("start_2_05",  0, 0, 0, 1, 0, 8'd0,  6'd0,  8'd2,  6'd5, 1, 0, 0);
    for (int i = 1; i <= 125; i++) begin
      rem = 125 - i;
      step("tick_run", 1, 0, 0, 0, 0, 8'd0, 6'd0, 8'(rem / 60), 6'(rem % 60),
           rem != 0, rem == 0, rem == 0);
    end
    step("done_drops",  0, 0, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 1, 0);
    step("exp_st_tick", 1, 0, 0, 1, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 1, 0);
    step("exp_pause",   0, 0, 0, 0, 1, 8'd0,  6'd0,  8'd0,  6'd0, 0, 1, 0);
    step("exp_load_03", 0, 0, 1, 0, 0, 8'd0,  6'd3,  8'd0,  6'd3, 0, 0, 0);

    // Minutes borrow.
    step("load_1_00",   0, 0, 1, 0, 0, 8'd1,  6'd0,  8'd1,  6'd0, 0, 0, 0);
    step("start_1_00",  0, 0, 0, 1, 0, 8'd0,  6'd0,  8'd1,  6'd0, 1, 0, 0);
    step("borrow",      1, 0, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd59, 1, 0, 0);
    step("load_in_run", 0, 0, 1, 0, 0, 8'd250, 6'd63, 8'd0, 6'd59, 1, 0, 0);
    step("clr_run",     0, 1, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 0, 0);

    // Saturation.
    step("saturate",    0, 0, 1, 0, 0, 8'd250, 6'd63, 8'd199, 6'd59, 0, 0, 0);
    step("sat_edge",    0, 0, 1, 0, 0, 8'd199, 6'd60, 8'd199, 6'd59, 0, 0, 0);

    // Pause beats tick; ticks ignored while paused.
    step("load_0_10",   0, 0, 1, 0, 0, 8'd0,  6'd10, 8'd0,  6'd10, 0, 0, 0);
    step("start_0_10",  0, 0, 0, 1, 0, 8'd0,  6'd0,  8'd0,  6'd10, 1, 0, 0);
    step("pause_tick",  1, 0, 0, 0, 1, 8'd0,  6'd0,  8'd0,  6'd10, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("paused_tick", 1, 0, 0, 0, 0, 8'd0, 6'd0, 8'd0, 6'd10, 0, 0, 0);
    step("resume",      0, 0, 0, 1, 0, 8'd0,  6'd0,  8'd0,  6'd10, 1, 0, 0);
    step("tick_0_09",   1, 0, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd9, 1, 0, 0);
    step("pause_again", 0, 0, 0, 0, 1, 8'd0,  6'd0,  8'd0,  6'd9, 0, 0, 0);
    step("p_start_tick", 1, 0, 0, 1, 0, 8'd0, 6'd0,  8'd0,  6'd9, 1, 0, 0);
    step("tick_0_08",   1, 0, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd8, 1, 0, 0);
    step("clr_0_08",    0, 1, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 0, 0);

    // Zero preset cannot start.
    step("load_0_00",   0, 0, 1, 0, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 0, 0);
    step("start_zero",  1, 0, 0, 1, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 0, 0);

    // clr wins over load and tick.
    step("load_0_20",   0, 0, 1, 0, 0, 8'd0,  6'd20, 8'd0,  6'd20, 0, 0, 0);
    step("start_0_20",  0, 0, 0, 1, 0, 8'd0,  6'd0,  8'd0,  6'd20, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("tick_0_20", 1, 0, 0, 0, 0, 8'd0, 6'd0, 8'd0, 6'(20 - i), 1, 0, 0);
    step("clr_ld_tick", 1, 1, 1, 0, 0, 8'd7,  6'd7,  8'd0,  6'd0, 0, 0, 0);

    // Async reset mid-run.
    step("load_0_20b",  0, 0, 1, 0, 0, 8'd0,  6'd20, 8'd0,  6'd20, 0, 0, 0);
    step("start_0_20b", 0, 0, 0, 1, 0, 8'd0,  6'd0,  8'd0,  6'd20, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("tick_0_20b", 1, 0, 0, 0, 0, 8'd0, 6'd0, 8'd0, 6'(20 - i), 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_now("reset_hold", 8'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start and tick together from IDLE: state change only, then expire.
    step("load_0_02",   0, 0, 1, 0, 0, 8'd0,  6'd2,  8'd0,  6'd2, 0, 0, 0);
    step("i_start_tick", 1, 0, 0, 1, 0, 8'd0, 6'd0,  8'd0,  6'd2, 1, 0, 0);
    step("tick_0_01",   1, 0, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd1, 1, 0, 0);
    step("expire",      1, 0, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 1, 1);
    step("no_2nd_done", 1, 0, 0, 1, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 1, 0);
    step("clr_expired", 0, 1, 0, 0, 0, 8'd0,  6'd0,  8'd0,  6'd0, 0, 0, 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable minutes:seconds down-counter, the counterpart of the up-counting minutes counter in the stopwatch datapath. It loads a preset time, decrements once per external 1 Hz tick while running, and flags expiry at 00:00. It sits beside the stopwatch counters and is driven by the same tick generator and button-sync logic.

Parameters:
MAX_MIN, 199, largest loadable minutes value; larger loads saturate to this value
MIN_W, 8, minutes field width; must hold MAX_MIN

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  1-cycle enable pulse, one per second
clr  input  1  synchronous clear to 00:00 and IDLE
load  input  1  load preset from load_min/load_sec
load_min  input  MIN_W  preset minutes
load_sec  input  6  preset seconds
start  input  1  begin or resume countdown
pause  input  1  suspend countdown
minutes  output  MIN_W  current minutes
seconds  output  6  current seconds, 0..59
running  output  1  high while in RUN
expired  output  1  high while in EXPIRED
done  output  1  1-cycle pulse when the count reaches 00:00

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All state is updated on posedge clk and cleared on negedge rst_n.
- Reset values: minutes=0, seconds=0, state=IDLE, running=0, expired=0, done=0.
- States: IDLE, RUN, PAUSED, EXPIRED. running = (state==RUN) and expired = (state==EXPIRED), both decoded from registered state.
- Per-cycle priority: clr > load > pause > start > tick.
- clr in any state: count=00:00, state=IDLE, done=0.
- load is honoured in IDLE, PAUSED and EXPIRED and ignored in RUN.
  - On load: minutes = min(load_min, MAX_MIN), seconds = min(load_sec, 59), state=IDLE.
- IDLE:
  - start with count != 00:00 -> RUN.
  - start with count == 00:00 is ignored; state stays IDLE.
  - tick is ignored.
- RUN:
  - pause -> PAUSED; no decrement that cycle, even if tick is also high.
  - tick without pause decrements the count:
    - seconds>0: seconds-1.
    - seconds==0 and minutes>0: minutes-1, seconds=59.
  - A tick at 00:01 (or at 01:00 down to 00:59, and so on, as normal) is decremented as usual. When the tick takes the count from 00:01 to 00:00, state goes to EXPIRED and done=1 on the same edge.
- PAUSED:
  - start -> RUN.
  - tick is ignored; the count is held.
- EXPIRED:
  - The count is held at 00:00.
  - start, pause and tick are ignored.
  - Only load or clr leave this state (both go to IDLE).
- done is high for exactly one cycle per expiry. It is never asserted by clr, load or reset.
- start and tick in the same cycle in IDLE or PAUSED: state changes only; the first decrement happens on the next tick.
- The count never wraps below 00:00 and never underflows minutes.
- Asynchronous reset mid-countdown returns to the reset values immediately, with no done pulse.
- Latency: outputs are registered and change on the edge after the qualifying input cycle.

Test Plan:
- Reset, then load_min=2, load_sec=5, load -> minutes=2, seconds=5, IDLE. Then start and 125 ticks -> 00:00 on the 125th tick, done high for 1 cycle, expired=1.
- Load 1:00, start, one tick -> 00:59 (minutes borrow, seconds reload to 59).
- Saturation: load_min=250, load_sec=63 -> minutes=199, seconds=59.
- In RUN at 00:10, pause and tick in the same cycle -> PAUSED, still 00:10. Then 3 ticks -> 00:10. Then start -> RUN, next tick -> 00:09.
- Load 00:00, start -> stays IDLE, running=0, no done. In EXPIRED, start and tick -> still 00:00 with no second done pulse. Then load 0:03 -> IDLE, 00:03.
- Load 0:20, start, 5 ticks (00:15), then clr together with load and tick -> 00:00, IDLE, done=0. Repeat the sequence and assert rst_n low mid-run -> all outputs 0 immediately.
